// File: rtl/append_sha.sv
// Appends an HMAC tag beat to each payload packet while forking a copy of the
// payload to the hash engine. OUT and HSH are independent skid-free registers.
module append_sha #(
   parameter int DATA_WIDTH = 512,
   parameter int ID_WIDTH   = 6,
   parameter int TAG_WIDTH  = 256
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    inp_valid,
   output logic                    inp_ready,
   input  logic [DATA_WIDTH-1:0]   inp_data,
   input  logic [DATA_WIDTH/8-1:0] inp_keep,
   input  logic [ID_WIDTH-1:0]     inp_id,
   input  logic                    inp_last,
   output logic                    hash_valid,
   input  logic                    hash_ready,
   output logic [DATA_WIDTH-1:0]   hash_data,
   output logic [DATA_WIDTH/8-1:0] hash_keep,
   output logic [ID_WIDTH-1:0]     hash_id,
   output logic                    hash_last,
   input  logic                    tag_valid,
   output logic                    tag_ready,
   input  logic [TAG_WIDTH-1:0]    tag_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [DATA_WIDTH/8-1:0] out_keep,
   output logic [ID_WIDTH-1:0]     out_id,
   output logic                    out_last,
   output logic [31:0]             pkt_count
);

   localparam int KEEP_W    = DATA_WIDTH / 8;
   localparam int TAG_BYTES = TAG_WIDTH / 8;

   typedef enum logic {PAYLOAD = 1'b0, WAIT_TAG = 1'b1} state_t;

   state_t              state_q, state_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [KEEP_W-1:0]   out_keep_q, out_keep_d;
   logic [ID_WIDTH-1:0] out_id_q, out_id_d;
   logic                out_last_q, out_last_d;
   logic                hsh_valid_q, hsh_valid_d;
   logic [DATA_WIDTH-1:0] hsh_data_q, hsh_data_d;
   logic [KEEP_W-1:0]   hsh_keep_q, hsh_keep_d;
   logic [ID_WIDTH-1:0] hsh_id_q, hsh_id_d;
   logic                hsh_last_q, hsh_last_d;
   logic [ID_WIDTH-1:0] id_reg_q, id_reg_d;
   logic [31:0]         pkt_count_q, pkt_count_d;

   logic                out_free, hsh_free, inp_fire, tag_fire, out_fire, hsh_fire;
   logic [KEEP_W-1:0]   tag_keep;

   always_comb begin
      out_free  = !out_valid_q || out_ready;
      hsh_free  = !hsh_valid_q || hash_ready;
      // Readies are gated by reset so nothing is accepted in the reset cycle.
      inp_ready = reset && (state_q == PAYLOAD) && out_free && hsh_free;
      tag_ready = reset && (state_q == WAIT_TAG) && out_free;
      inp_fire  = inp_valid && inp_ready;
      tag_fire  = tag_valid && tag_ready;
      out_fire  = out_valid_q && out_ready;
      hsh_fire  = hsh_valid_q && hash_ready;

      for (int i = 0; i < KEEP_W; i++) tag_keep[i] = (i < TAG_BYTES);

      state_d     = state_q;
      id_reg_d    = id_reg_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_id_d    = out_id_q;
      out_last_d  = out_last_q;
      hsh_valid_d = hsh_valid_q;
      hsh_data_d  = hsh_data_q;
      hsh_keep_d  = hsh_keep_q;
      hsh_id_d    = hsh_id_q;
      hsh_last_d  = hsh_last_q;
      pkt_count_d = pkt_count_q + 32'(out_fire && out_last_q);

      if (hsh_fire) hsh_valid_d = 1'b0;
      if (out_fire) out_valid_d = 1'b0;

      // inp_fire and tag_fire are mutually exclusive via the state.
      if (inp_fire) begin
         hsh_valid_d = 1'b1;
         hsh_data_d  = inp_data;
         hsh_keep_d  = inp_keep;
         hsh_id_d    = inp_id;
         hsh_last_d  = inp_last;
         out_valid_d = 1'b1;
         out_data_d  = inp_data;
         out_keep_d  = inp_keep;
         out_id_d    = inp_id;
         out_last_d  = 1'b0;
         if (inp_last) begin
            id_reg_d = inp_id;
            state_d  = WAIT_TAG;
         end
      end else if (tag_fire) begin
         out_valid_d                = 1'b1;
         out_data_d                 = '0;
         out_data_d[TAG_WIDTH-1:0]  = tag_data;
         out_keep_d                 = tag_keep;
         out_id_d                   = id_reg_q;
         out_last_d                 = 1'b1;
         state_d                    = PAYLOAD;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= PAYLOAD;
         id_reg_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_id_q    <= '0;
         out_last_q  <= 1'b0;
         hsh_valid_q <= 1'b0;
         hsh_data_q  <= '0;
         hsh_keep_q  <= '0;
         hsh_id_q    <= '0;
         hsh_last_q  <= 1'b0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         id_reg_q    <= id_reg_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_id_q    <= out_id_d;
         out_last_q  <= out_last_d;
         hsh_valid_q <= hsh_valid_d;
         hsh_data_q  <= hsh_data_d;
         hsh_keep_q  <= hsh_keep_d;
         hsh_id_q    <= hsh_id_d;
         hsh_last_q  <= hsh_last_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_keep   = out_keep_q;
   assign out_id     = out_id_q;
   assign out_last   = out_last_q;
   assign hash_valid = hsh_valid_q;
   assign hash_data  = hsh_data_q;
   assign hash_keep  = hsh_keep_q;
   assign hash_id    = hsh_id_q;
   assign hash_last  = hsh_last_q;
   assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_append_sha.sv
// Scoreboarded bench for append_sha: table of packet scenarios plus
// hand-written back-to-back and mid-packet reset sequences.
module tb_append_sha;

   localparam int DW = 512;
   localparam int KW = DW / 8;
   localparam int IW = 6;
   localparam int TW = 256;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic [IW-1:0] id;
      logic          last;
   } beat_t;

   typedef struct {
      int            nbeats;
      logic [IW-1:0] id;
      int            tag_dly;
      int            omode;   // 0 ready, 1 toggle, 2 random, 3 stalled
      int            hhold;
      logic [TW-1:0] tag;
      int            exp_out;
   } vec_t;

   logic clock = 0, reset = 0;
   logic inp_valid = 0, inp_last = 0;
   logic [DW-1:0] inp_data = '0;
   logic [KW-1:0] inp_keep = '0;
   logic [IW-1:0] inp_id = '0;
   logic inp_ready;
   logic hash_valid, hash_last, hash_ready;
   logic [DW-1:0] hash_data;
   logic [KW-1:0] hash_keep;
   logic [IW-1:0] hash_id;
   logic tag_valid = 0, tag_ready;
   logic [TW-1:0] tag_data = '0;
   logic out_valid, out_last, out_ready;
   logic [DW-1:0] out_data;
   logic [KW-1:0] out_keep;
   logic [IW-1:0] out_id;
   logic [31:0] pkt_count;

   append_sha #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .TAG_WIDTH(TW)) dut (
      .clock(clock), .reset(reset),
      .inp_valid(inp_valid), .inp_ready(inp_ready), .inp_data(inp_data),
      .inp_keep(inp_keep), .inp_id(inp_id), .inp_last(inp_last),
      .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_data(hash_data),
      .hash_keep(hash_keep), .hash_id(hash_id), .hash_last(hash_last),
      .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_data(tag_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_keep(out_keep), .out_id(out_id), .out_last(out_last),
      .pkt_count(pkt_count)
   );

   always #5 clock = ~clock;

   int n_tests = 0, n_fail = 0;
   beat_t out_q[$], hsh_q[$];
   int out_seen = 0;
   int exp_pkts = 0;
   logic tb_in_wait = 0;
   logic [IW-1:0] tb_last_id = '0;
   int omode = 0, hold_cnt = 0;

   task automatic check(input string nm, input logic [599:0] act, input logic [599:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [TW-1:0] rnd_tag();
      logic [TW-1:0] r;
      for (int i = 0; i < TW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Ready generators for the two output channels.
   initial begin
      out_ready  = 1;
      hash_ready = 1;
      forever begin
         @(posedge clock); #1;
         case (omode)
            0: out_ready = 1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 0;
         endcase
         hash_ready = (hold_cnt == 0);
         if (hold_cnt > 0) hold_cnt--;
      end
   end

   // Output monitors: scoreboard pops, hold-stability and early-tag checks.
   beat_t o_snap, h_snap;
   logic o_stall = 0, h_stall = 0;
   always @(negedge clock) begin
      beat_t cur_o, cur_h, e;
      cur_o = '{data: out_data, keep: out_keep, id: out_id, last: out_last};
      cur_h = '{data: hash_data, keep: hash_keep, id: hash_id, last: hash_last};
      if (!reset) begin
         o_stall = 0;
         h_stall = 0;
      end else begin
         if (o_stall) check("out_stable", 600'({out_valid, cur_o}), 600'({1'b1, o_snap}));
         if (h_stall) check("hash_stable", 600'({hash_valid, cur_h}), 600'({1'b1, h_snap}));
         if (out_valid && out_ready) begin
            out_seen++;
            if (out_q.size() == 0) check("out_unexpected", 600'(cur_o), 600'(0));
            else begin e = out_q.pop_front(); check("out_beat", 600'(cur_o), 600'(e)); end
         end
         if (hash_valid && hash_ready) begin
            if (hsh_q.size() == 0) check("hash_unexpected", 600'(cur_h), 600'(0));
            else begin e = hsh_q.pop_front(); check("hash_beat", 600'(cur_h), 600'(e)); end
         end
         if (tag_valid && !tb_in_wait) check("tag_held_off", 600'(tag_ready), 600'(0));
         o_stall = out_valid && !out_ready;
         o_snap  = cur_o;
         h_stall = hash_valid && !hash_ready;
         h_snap  = cur_h;
      end
   end

   // Called and returns at posedge+1.
   task automatic send_pkt(input logic [IW-1:0] id, input int n);
      beat_t b;
      logic ok;
      for (int k = 0; k < n; k++) begin
         b.data = rnd_data();
         b.keep = {$urandom, $urandom};
         b.id   = id;
         b.last = (k == n - 1);
         inp_data = b.data; inp_keep = b.keep; inp_id = b.id; inp_last = b.last;
         inp_valid = 1;
         ok = 0;
         for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clock); ok = inp_ready;
            @(posedge clock); #1;
         end
         if (!ok) check("inp_timeout", 600'(ok), 600'(1));
         else begin
            check("inp_not_in_wait", 600'(tb_in_wait), 600'(0));
            hsh_q.push_back(b);
            b.last = 0;
            out_q.push_back(b);
            if (k == n - 1) begin tb_in_wait = 1; tb_last_id = id; end
         end
      end
      inp_valid = 0;
      inp_last  = 0;
   endtask

   task automatic send_tag(input logic [TW-1:0] tg, input int dly);
      beat_t b;
      logic ok;
      repeat (dly) begin @(posedge clock); #1; end
      tag_data  = tg;
      tag_valid = 1;
      ok = 0;
      for (int t = 0; t < 1000 && !ok; t++) begin
         @(negedge clock); ok = tag_ready;
         @(posedge clock); #1;
      end
      if (!ok) check("tag_timeout", 600'(ok), 600'(1));
      else begin
         b.data = DW'(tg);
         b.keep = {32'h0, 32'hFFFF_FFFF};
         b.id   = tb_last_id;
         b.last = 1;
         out_q.push_back(b);
         tb_in_wait = 0;
         exp_pkts++;
      end
      tag_valid = 0;
   endtask

   task automatic drain();
      for (int t = 0; t < 2000 && (out_q.size() != 0 || hsh_q.size() != 0); t++) @(negedge clock);
      check("drained", 600'({out_q.size() != 0, hsh_q.size() != 0}), 600'(0));
      @(posedge clock); #1;
   endtask

   task automatic run_vec(input vec_t v);
      omode    = v.omode;
      hold_cnt = v.hhold;
      out_seen = 0;
      fork
         send_pkt(v.id, v.nbeats);
         send_tag(v.tag, v.tag_dly);
      join
      omode = 0;
      drain();
      check("out_beats", 600'(out_seen), 600'(v.exp_out));
      @(negedge clock);
      check("pkt_count", 600'(pkt_count), 600'(exp_pkts));
      @(posedge clock); #1;
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{nbeats: 3, id: 6'd5,  tag_dly: 4, omode: 0, hhold: 0,  tag: {32{8'hA5}}, exp_out: 4};
      vecs[1] = '{nbeats: 2, id: 6'd9,  tag_dly: 0, omode: 0, hhold: 0,  tag: rnd_tag(),   exp_out: 3};
      vecs[2] = '{nbeats: 4, id: 6'd12, tag_dly: 2, omode: 0, hhold: 10, tag: rnd_tag(),   exp_out: 5};
      vecs[3] = '{nbeats: 3, id: 6'd33, tag_dly: 1, omode: 1, hhold: 0,  tag: rnd_tag(),   exp_out: 4};
      vecs[4] = '{nbeats: 5, id: 6'd63, tag_dly: 3, omode: 2, hhold: 6,  tag: rnd_tag(),   exp_out: 6};
      vecs[5] = '{nbeats: 1, id: 6'd7,  tag_dly: 0, omode: 1, hhold: 3,  tag: rnd_tag(),   exp_out: 2};

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_inp_ready", 600'(inp_ready), 600'(0));
      check("rst_tag_ready", 600'(tag_ready), 600'(0));
      check("rst_valids", 600'({out_valid, hash_valid}), 600'(0));
      check("rst_pkt_count", 600'(pkt_count), 600'(0));
      @(posedge clock); #1;
      reset = 1;
      @(negedge clock);
      check("post_rst_inp_ready", 600'(inp_ready), 600'(1));
      @(posedge clock); #1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Back-to-back single-beat packets with the tag offered continuously
      out_seen = 0;
      fork
         begin send_pkt(6'd1, 1); send_pkt(6'd2, 1); end
         begin send_tag(rnd_tag(), 0); send_tag(rnd_tag(), 0); end
      join
      drain();
      check("b2b_out_beats", 600'(out_seen), 600'(4));
      @(negedge clock);
      check("b2b_pkt_count", 600'(pkt_count), 600'(exp_pkts));
      @(posedge clock); #1;

      // Reset while in WAIT_TAG with beats stuck in both registers
      omode = 3; hold_cnt = 100;
      @(posedge clock); #1;
      send_pkt(6'd20, 1);
      tag_data = rnd_tag(); tag_valid = 1;
      repeat (2) begin @(posedge clock); #1; end
      reset = 0; omode = 0; hold_cnt = 0;
      @(negedge clock);
      check("rst_mid_inp_ready", 600'(inp_ready), 600'(0));
      check("rst_mid_tag_ready", 600'(tag_ready), 600'(0));
      @(posedge clock); #1;
      reset = 1; tag_valid = 0; tb_in_wait = 0;
      out_q.delete(); hsh_q.delete();
      exp_pkts = 0;
      @(negedge clock);
      check("rel_valids", 600'({out_valid, hash_valid}), 600'(0));
      check("rel_pkt_count", 600'(pkt_count), 600'(0));
      check("rel_inp_ready", 600'(inp_ready), 600'(1));
      check("rel_tag_ready", 600'(tag_ready), 600'(0));
      @(posedge clock); #1;
      run_vec(vecs[1]);

      repeat (3) @(posedge clock);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/append_sha.md
APPEND_SHA -- requirements
Module: append_sha

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, payload/output beat width in bits.
REQ-002 SHALL have parameter ID_WIDTH, default 6, tid width.
REQ-003 SHALL have parameter TAG_WIDTH, default 256, HMAC tag width (TAG_WIDTH <= DATA_WIDTH, multiple of 8).
REQ-004 SHALL have ports: clock  in  1  sole clock; reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: inp_valid in 1, inp_ready out 1, inp_data in DATA_WIDTH, inp_keep in DATA_WIDTH/8, inp_id in ID_WIDTH, inp_last in 1; these form the plaintext payload stream.
REQ-006 SHALL have ports: hash_valid out 1, hash_ready in 1, hash_data out DATA_WIDTH, hash_keep out DATA_WIDTH/8, hash_id out ID_WIDTH, hash_last out 1; these form the copy of the payload sent to the hmac engine.
REQ-007 SHALL have ports: tag_valid in 1, tag_ready out 1, tag_data in TAG_WIDTH; these carry the hmac result, one per packet.
REQ-008 SHALL have ports: out_valid out 1, out_ready in 1, out_data out DATA_WIDTH, out_keep out DATA_WIDTH/8, out_id out ID_WIDTH, out_last out 1; these form the signed stream (payload followed by the tag beat).
REQ-009 SHALL have port pkt_count  out  32  number of tag beats accepted on out.

Function
REQ-010 SHALL implement FSM states PAYLOAD and WAIT_TAG.
REQ-011 SHALL hold one output register (OUT) and one hash register (HSH), each with its own valid flag; out_* and hash_* SHALL be driven only from these registers.
REQ-012 SHALL drive inp_ready = (state==PAYLOAD) && (!out_valid || out_ready) && (!hash_valid || hash_ready).
REQ-013 On input handshake, SHALL load the beat into both OUT and HSH (one-cycle latency, data/keep/id unchanged); HSH SHALL carry hash_last = inp_last; OUT SHALL carry out_last = 0.
REQ-014 On an input handshake with inp_last=1, SHALL capture inp_id into ID_REG and enter WAIT_TAG.
REQ-015 OUT and HSH SHALL drain independently; a valid flag SHALL clear on its own handshake unless reloaded in the same cycle.
REQ-016 SHALL drive tag_ready = (state==WAIT_TAG) && (!out_valid || out_ready); tag_ready SHALL be 0 in PAYLOAD, so an early tag_valid is held off until WAIT_TAG.
REQ-017 On a tag handshake, SHALL load OUT with the tag beat and return to PAYLOAD:
- out_data = zero-extended tag_data in the low TAG_WIDTH bits;
- out_keep = low TAG_WIDTH/8 bits set, others 0;
- out_id = ID_REG;
- out_last = 1.
REQ-018 In WAIT_TAG, inp_ready SHALL be 0; no beat of the next packet SHALL enter before the tag beat is loaded.
REQ-019 SHALL increment pkt_count by 1 on each out handshake with out_last=1; it SHALL wrap from 0xFFFFFFFF to 0.
REQ-020 out_valid/hash_valid SHALL stay asserted with stable payload until their handshake (AXI-Stream rule); valid SHALL NOT depend combinationally on the same channel's ready.
REQ-021 Single-beat packets SHALL be legal: one payload beat (out_last=0) followed by the tag beat.
REQ-022 Back-to-back: the tag beat and the first beat of the next packet SHALL NOT be loaded in the same cycle; ordering on out SHALL be strictly payload…, tag, payload….

Reset
REQ-023 While reset=0 at a rising clock edge, SHALL force state=PAYLOAD, out_valid=0, hash_valid=0, pkt_count=0, ID_REG=0; inp_ready and tag_ready SHALL be 0 during the reset cycle.
REQ-024 Reset asserted mid-packet or in WAIT_TAG SHALL discard buffered beats and the pending tag wait; the first cycle after release SHALL accept a new packet.

Verification
REQ-025 3-beat packet, id=5, all readies 1, tag=0xA5…A5 after 4 cycles -> out: 3 beats last=0, then beat keep=0x…FFFFFFFF, id=5, last=1; hash: 3 beats with last on beat 3; pkt_count=1.
REQ-026 tag_valid=1 held from cycle 0 of the packet -> tag_ready stays 0 until inp_last accepted; tag consumed exactly once.
REQ-027 hash_ready=0 for 10 cycles while out_ready=1 -> inp_ready=0 after first beat; no beat lost or duplicated on either side.
REQ-028 out_ready toggling 1/0 during the tag beat -> tag data/keep/id stable while out_valid=1 until accepted.
REQ-029 Two back-to-back single-beat packets, ids 1 and 2 -> out order P1, T1(id1), P2, T2(id2); pkt_count=2.
REQ-030 reset=0 in WAIT_TAG for 1 cycle -> out_valid=0, pkt_count=0, inp_ready=1 the next cycle (readies high).
